// File: rtl/obstacle_scroller_if.sv
// Obstacle scroller bus: game/detector controls in, obstacle coordinates out.
interface obstacle_scroller_if;
    logic       enable;
    logic       frame_tick;
    logic       collision;
    logic [7:0] block_x;
    logic [6:0] block_y;
    logic [1:0] block_width;
    logic [1:0] block_height;
    logic       block_valid;
    logic       hit;
    logic       passed;

    // Game FSM / collision detector side
    modport master (
        output enable, frame_tick, collision,
        input  block_x, block_y, block_width, block_height, block_valid, hit, passed
    );

    // Obstacle scroller side
    modport slave (
        input  enable, frame_tick, collision,
        output block_x, block_y, block_width, block_height, block_valid, hit, passed
    );
endinterface

// File: rtl/obstacle_scroller.sv
// Obstacle scroller: spawns one random-sized obstacle at the right edge,
// scrolls it left, halts it on collision and inserts a random gap after it
// leaves the screen.
// Optional feature macro OBSTACLE_SPEEDUP_EN: every 8 passed obstacles the
// move divider drops by one (floor 1); it is restored on reset or IDLE.
module obstacle_scroller #(
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned GROUND_Y  = 100,
    parameter int unsigned STEP      = 1,
    parameter int unsigned SPEED_DIV = 2,
    parameter int unsigned GAP_MIN   = 4
) (
    input  logic               clock,
    input  logic               resetn,
    obstacle_scroller_if.slave bus
);
    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned GAP_W  = 8;

    localparam logic [X_W-1:0]    SPAWN_X  = X_W'(SCREEN_W - 1);
    localparam logic [X_W-1:0]    STEP_X   = X_W'(STEP);
    localparam logic [Y_W-1:0]    GROUND   = Y_W'(GROUND_Y);
    localparam logic [GAP_W-1:0]  GAP_BASE = GAP_W'(GAP_MIN);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        MOVE,
        GAP,
        HALT
    } state_t;

    state_t              state;
    logic [7:0]          lfsr;
    logic                lfsr_fb;
    logic [TICK_W-1:0]   tick_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [TICK_W-1:0]   div_m1;
    logic [1:0]          new_w;
    logic [1:0]          new_h;

    logic [X_W-1:0]      pos_x;
    logic [Y_W-1:0]      pos_y;
    logic [1:0]          size_w;
    logic [1:0]          size_h;
    logic                valid;
    logic                hit_pulse;
    logic                pass_pulse;

    // Size draw from the LFSR, zero mapped to one so the obstacle is never empty
    assign new_w   = (lfsr[1:0] == 2'd0) ? 2'd1 : lfsr[1:0];
    assign new_h   = (lfsr[3:2] == 2'd0) ? 2'd1 : lfsr[3:2];
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

`ifdef OBSTACLE_SPEEDUP_EN
    logic [2:0]        pass_cnt;
    logic [TICK_W-1:0] eff_div;

    assign div_m1 = eff_div - TICK_W'(1);

    // Pass counter; each wrap speeds the scroll up by one divider step
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pass_cnt <= 3'd0;
            eff_div  <= TICK_W'(SPEED_DIV);
        end else if (!bus.enable) begin
            eff_div  <= TICK_W'(SPEED_DIV);
        end else if (pass_pulse) begin
            pass_cnt <= pass_cnt + 3'd1;
            if (pass_cnt == 3'd7 && eff_div > TICK_W'(1)) begin
                eff_div <= eff_div - TICK_W'(1);
            end
        end
    end
`else
    assign div_m1 = TICK_W'(SPEED_DIV - 1);
`endif

    // Obstacle life-cycle FSM with registered coordinates and pulses
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pos_x      <= '0;
            pos_y      <= GROUND;
            size_w     <= 2'd0;
            size_h     <= 2'd0;
            valid      <= 1'b0;
            hit_pulse  <= 1'b0;
            pass_pulse <= 1'b0;
            tick_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            hit_pulse  <= 1'b0;
            pass_pulse <= 1'b0;
            if (!bus.enable) begin
                state <= IDLE;
                valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SPAWN;
                    end
                    SPAWN: begin
                        size_w   <= new_w;
                        size_h   <= new_h;
                        pos_y    <= GROUND - Y_W'(new_h);
                        pos_x    <= SPAWN_X;
                        valid    <= 1'b1;
                        tick_cnt <= '0;
                        state    <= MOVE;
                    end
                    MOVE: begin
                        // Collision outranks a coincident move event
                        if (bus.collision && valid) begin
                            hit_pulse <= 1'b1;
                            state     <= HALT;
                        end else if (bus.frame_tick) begin
                            if (tick_cnt >= div_m1) begin
                                tick_cnt <= '0;
                                if (pos_x >= STEP_X) begin
                                    pos_x <= pos_x - STEP_X;
                                end else begin
                                    valid      <= 1'b0;
                                    pass_pulse <= 1'b1;
                                    gap_cnt    <= GAP_BASE + GAP_W'(lfsr[6:4]);
                                    state      <= GAP;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == '0) begin
                            state <= SPAWN;
                        end else if (bus.frame_tick) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.block_x      = pos_x;
    assign bus.block_y      = pos_y;
    assign bus.block_width  = size_w;
    assign bus.block_height = size_h;
    assign bus.block_valid  = valid;
    assign bus.hit          = hit_pulse;
    assign bus.passed       = pass_pulse;
endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed scoreboard bench for obstacle_scroller (default parameters).
module tb_obstacle_scroller;
    localparam int SCREEN_W = 160;
    localparam int GROUND_Y = 100;
    localparam int GAP_MIN  = 4;
    localparam int SPAWN_X  = SCREEN_W - 1;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    logic       clock;
    logic       resetn;
    logic [7:0] m_lfsr;
    logic [7:0] lfsr_at_edge;
    exp_t       sb_q[$];
    int         checks;
    int         failures;

    obstacle_scroller_if bus ();

    obstacle_scroller dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps every clock out of reset
    always @(posedge clock or negedge resetn) begin
        if (!resetn) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic push_exp(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === 32'(e.val)) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, observed, e.val);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input int expected);
        push_exp(tag, expected);
        pop_check(observed);
    endtask

    // One clock; remembers the LFSR value the DUT saw on that edge
    task automatic step();
        lfsr_at_edge = m_lfsr;
        @(posedge clock);
        #1;
    endtask

    // Waits for block_valid to rise, then checks the spawned obstacle
    task automatic wait_spawn(input bit no_hit, output int n);
        int w;
        int h;
        n = 0;
        while (bus.block_valid !== 1'b1 && n < 400) begin
            step();
            n++;
            if (no_hit) check("gap_collision_ignored", 32'(bus.hit), 0);
        end
        bus.collision = 1'b0;
        check("spawn_valid", 32'(bus.block_valid), 1);
        w = (lfsr_at_edge[1:0] == 2'd0) ? 1 : int'(lfsr_at_edge[1:0]);
        h = (lfsr_at_edge[3:2] == 2'd0) ? 1 : int'(lfsr_at_edge[3:2]);
        check("spawn_x", 32'(bus.block_x), SPAWN_X);
        check("spawn_w", 32'(bus.block_width), w);
        check("spawn_h", 32'(bus.block_height), h);
        check("spawn_y", 32'(bus.block_y), GROUND_Y - h);
    endtask

    // Scrolls a freshly spawned obstacle off the left edge at divider 2
    task automatic scroll_to_pass(output int gap_exp);
        for (int k = 1; k <= SPAWN_X; k++) begin
            step();
            step();
            push_exp("scroll_x", SPAWN_X - k);
            pop_check(32'(bus.block_x));
        end
        step();
        step();
        check("pass_pulse", 32'(bus.passed), 1);
        check("pass_valid", 32'(bus.block_valid), 0);
        check("pass_x_no_wrap", 32'(bus.block_x), 0);
        check("pass_no_hit", 32'(bus.hit), 0);
        gap_exp = GAP_MIN + int'(lfsr_at_edge[6:4]);
    endtask

    initial begin
        int n;
        int gap_exp;
        int k;
        checks   = 0;
        failures = 0;

        // Reset held with active inputs
        resetn         = 1'b0;
        bus.enable     = 1'b1;
        bus.collision  = 1'b1;
        bus.frame_tick = 1'b1;
        lfsr_at_edge   = 8'h00;
        repeat (3) step();
        check("reset_x", 32'(bus.block_x), 0);
        check("reset_y", 32'(bus.block_y), GROUND_Y);
        check("reset_w", 32'(bus.block_width), 0);
        check("reset_h", 32'(bus.block_height), 0);
        check("reset_valid", 32'(bus.block_valid), 0);
        check("reset_hit", 32'(bus.hit), 0);
        check("reset_passed", 32'(bus.passed), 0);

        // Release: IDLE -> SPAWN, then obstacle appears
        resetn        = 1'b1;
        bus.collision = 1'b0;
        step();
        check("spawn_cycle_valid", 32'(bus.block_valid), 0);
        wait_spawn(1'b0, n);
        check("spawn_latency", 32'(n), 1);

        // Full scroll, pass pulse width, then gap length
        scroll_to_pass(gap_exp);
        step();
        check("pass_one_cycle", 32'(bus.passed), 0);
        wait_spawn(1'b0, n);
        check("gap_ticks", 32'(n - 1), gap_exp);
        check("gap_in_range", 32'((n - 1 >= 4) && (n - 1 <= 11)), 1);

        // Hit at x=120, held collision, then disable
        k = 0;
        while (bus.block_x !== 8'd120 && k < 400) begin
            step();
            k++;
        end
        check("reach_x120", 32'(bus.block_x), 120);
        bus.collision = 1'b1;
        step();
        check("hit_pulse", 32'(bus.hit), 1);
        check("hit_no_pass", 32'(bus.passed), 0);
        check("hit_x", 32'(bus.block_x), 120);
        for (int i = 0; i < 50; i++) begin
            step();
            check("halt_no_rehit", 32'(bus.hit), 0);
        end
        check("halt_x", 32'(bus.block_x), 120);
        check("halt_valid", 32'(bus.block_valid), 1);
        bus.enable = 1'b0;
        step();
        check("disable_valid", 32'(bus.block_valid), 0);
        check("disable_hit", 32'(bus.hit), 0);
        step();
        check("idle_collision_ignored", 32'(bus.hit), 0);
        bus.collision = 1'b0;

        // Collision coincident with the final move event
        bus.enable = 1'b1;
        wait_spawn(1'b0, n);
        k = 0;
        while (bus.block_x !== 8'd0 && k < 400) begin
            step();
            k++;
        end
        check("reach_x0", 32'(bus.block_x), 0);
        step();
        bus.collision = 1'b1;
        step();
        check("simul_hit", 32'(bus.hit), 1);
        check("simul_no_pass", 32'(bus.passed), 0);
        check("simul_x", 32'(bus.block_x), 0);
        check("simul_valid", 32'(bus.block_valid), 1);
        step();
        check("simul_halt_no_rehit", 32'(bus.hit), 0);
        check("simul_halt_valid", 32'(bus.block_valid), 1);
        bus.enable    = 1'b0;
        bus.collision = 1'b0;
        step();

        // Collision during GAP and SPAWN is ignored
        bus.enable = 1'b1;
        wait_spawn(1'b0, n);
        scroll_to_pass(gap_exp);
        bus.collision = 1'b1;
        wait_spawn(1'b1, n);
        check("gap2_ticks", 32'(n - 2), gap_exp);
        step();
        check("after_gap_no_hit", 32'(bus.hit), 0);

        // Asynchronous reset mid-scroll
        repeat (5) step();
        resetn = 1'b0;
        #2;
        check("async_valid", 32'(bus.block_valid), 0);
        check("async_x", 32'(bus.block_x), 0);
        check("async_y", 32'(bus.block_y), GROUND_Y);
        check("async_w", 32'(bus.block_width), 0);
        step();
        resetn = 1'b1;

`ifdef OBSTACLE_SPEEDUP_EN
        // Eight passes drop the divider from 2 to 1; enable toggle restores it
        step();
        for (int p = 0; p < 8; p++) begin
            wait_spawn(1'b0, n);
            scroll_to_pass(gap_exp);
        end
        wait_spawn(1'b0, n);
        step();
        check("fast_x", 32'(bus.block_x), SPAWN_X - 1);
        bus.enable = 1'b0;
        step();
        bus.enable = 1'b1;
        step();
        wait_spawn(1'b0, n);
        step();
        check("restored_hold_x", 32'(bus.block_x), SPAWN_X);
        step();
        check("restored_move_x", 32'(bus.block_x), SPAWN_X - 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
